// File: rtl/display_instancias.sv
// Serial shift-and-add-3 conversion of the 8-bit match count into three 7-segment digits.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (units digit always shown).
module display_instancias (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instancias,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic       busy,
    output logic       done,
    output logic [1:0] disp_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  last;
    logic        pend;
    logic [7:0]  sh;
    logic [11:0] bcd;
    logic [11:0] bcd_adj;
    logic [2:0]  cnt;
    logic [11:0] dig;
    logic        start;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign start = pend || (instancias != last);

    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (cnt == 3'd7) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= '0;
            pend <= 1'b1;
            sh   <= '0;
            bcd  <= '0;
            cnt  <= '0;
            dig  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sh   <= instancias;
                        last <= instancias;
                        bcd  <= '0;
                        cnt  <= '0;
                        pend <= 1'b0;
                        busy <= 1'b1;
                    end
                end
                SHIFT: begin
                    {bcd, sh} <= {bcd_adj[10:0], sh, 1'b0};
                    cnt       <= cnt + 3'd1;
                end
                DONE: begin
                    dig  <= bcd;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        hex0 = seg7(dig[3:0]);
        hex1 = seg7(dig[7:4]);
        hex2 = seg7(dig[11:8]);
`ifdef LEADING_ZERO_BLANK_EN
        if (dig[11:8] == 4'd0) begin
            hex2 = '1;
            if (dig[7:4] == 4'd0)
                hex1 = '1;
        end
`endif
    end

    assign disp_state = state;

endmodule

// File: tb/tb_display_instancias.sv
// Scoreboard bench for display_instancias: expected hex triples queued at stimulus, checked on done.
module tb_display_instancias;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] instancias;
    logic [6:0] hex0, hex1, hex2;
    logic       busy, done;
    logic [1:0] disp_state;

    int total = 0;
    int bad   = 0;
    logic [20:0] sbq[$];

    display_instancias dut (
        .clk        (clk),
        .rst        (rst),
        .instancias (instancias),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .busy       (busy),
        .done       (done),
        .disp_state (disp_state)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_ref(input int d);
        logic [6:0] tbl [0:9];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return tbl[d];
    endfunction

    function automatic logic [20:0] exp_hex(input int v);
        int h, t, u;
        logic [6:0] e2, e1, e0;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        e2 = seg_ref(h);
        e1 = seg_ref(t);
        e0 = seg_ref(u);
`ifdef LEADING_ZERO_BLANK_EN
        if (h == 0) e2 = 7'b1111111;
        if (h == 0 && t == 0) e1 = 7'b1111111;
`endif
        return {e2, e1, e0};
    endfunction

    // Waits for a done pulse, sampling on falling edges; cycles counts samples taken.
    task automatic wait_done(input int limit, output int cycles, output bit seen, output int busy_n);
        cycles = 0;
        seen   = 0;
        busy_n = 0;
        while (cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) busy_n++;
        end
    endtask

    task automatic pop_check(input string name);
        logic [20:0] e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL %s: hex=%b_%b_%b but scoreboard empty", name, hex2, hex1, hex0);
        end else begin
            e = sbq.pop_front();
            if ({hex2, hex1, hex0} !== e) begin
                bad++;
                $display("FAIL %s: hex=%b_%b_%b expected %b_%b_%b", name,
                         hex2, hex1, hex0, e[20:14], e[13:7], e[6:0]);
            end
        end
    endtask

    task automatic test_reset;
        int cyc, bn, pulses;
        bit seen;
        rst = 1'b1;
        instancias = 8'd0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, disp_state} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl: busy=%b done=%b state=%0d expected 0 0 0", busy, done, disp_state);
        end
        total++;
        if ({hex2, hex1, hex0} !== exp_hex(0)) begin
            bad++;
            $display("FAIL reset_hex: %b_%b_%b expected %b", hex2, hex1, hex0, exp_hex(0));
        end
        sbq.push_back(exp_hex(0));
        rst = 1'b0;
        wait_done(20, cyc, seen, bn);
        total++;
        if (!seen || cyc != 10) begin
            bad++;
            $display("FAIL reset_latency: seen=%0d cycles=%0d expected 1 10", seen, cyc);
        end
        if (seen) pop_check("reset_zero_hex");
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL hold_no_done: pulses=%0d expected 0", pulses);
        end
    endtask

    task automatic test_convert(input int v);
        int cyc, bn;
        bit seen;
        instancias = 8'(v);
        sbq.push_back(exp_hex(v));
        wait_done(20, cyc, seen, bn);
        total++;
        if (!seen || cyc != 10) begin
            bad++;
            $display("FAIL conv_latency v=%0d: seen=%0d cycles=%0d expected 1 10", v, seen, cyc);
        end
        total++;
        if (bn != 9) begin
            bad++;
            $display("FAIL busy_cycles v=%0d: %0d expected 9", v, bn);
        end
        if (seen) pop_check($sformatf("conv_hex v=%0d", v));
        else void'(sbq.pop_front());
    endtask

    task automatic test_change_during_shift;
        int cyc, bn, pulses;
        bit seen;
        instancias = 8'd37;
        sbq.push_back(exp_hex(37));
        repeat (3) @(negedge clk);
        total++;
        if (disp_state !== 2'd1) begin
            bad++;
            $display("FAIL shift_state: state=%0d expected 1", disp_state);
        end
        instancias = 8'd38;
        repeat (2) @(negedge clk);
        instancias = 8'd99;
        sbq.push_back(exp_hex(99));
        wait_done(20, cyc, seen, bn);
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL change_first_done: not seen expected pulse");
        end else pop_check("change_first_37");
        wait_done(20, cyc, seen, bn);
        total++;
        if (!seen || cyc != 10) begin
            bad++;
            $display("FAIL change_second_done: seen=%0d cycles=%0d expected 1 10", seen, cyc);
        end
        if (seen) pop_check("change_second_99");
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL change_extra_done: pulses=%0d expected 0", pulses);
        end
    endtask

    task automatic test_rst_mid;
        int cyc, bn;
        bit seen;
        instancias = 8'd200;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, disp_state} !== 4'b0000) begin
            bad++;
            $display("FAIL rst_mid_ctrl: busy=%b done=%b state=%0d expected 0 0 0", busy, done, disp_state);
        end
        total++;
        if ({hex2, hex1, hex0} !== exp_hex(0)) begin
            bad++;
            $display("FAIL rst_mid_hex: %b_%b_%b expected %b", hex2, hex1, hex0, exp_hex(0));
        end
        sbq.push_back(exp_hex(200));
        rst = 1'b0;
        wait_done(20, cyc, seen, bn);
        total++;
        if (!seen || cyc != 10) begin
            bad++;
            $display("FAIL rst_mid_reconv: seen=%0d cycles=%0d expected 1 10", seen, cyc);
        end
        if (seen) pop_check("rst_mid_hex200");
    endtask

    task automatic test_sweep;
        for (int v = 0; v < 256; v++) test_convert(v);
    endtask

    initial begin
        rst = 1'b1;
        instancias = 8'd0;
        test_reset();
        test_convert(255);
        test_convert(109);
        test_change_during_shift();
        test_rst_mid();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
